// File: rtl/sram_arbiter_module_if.sv
// sram_arbiter_module_if: requester-side bundle for the SRAM arbiter
// rd_req/rd_addr   : VGA read request and pixel address (master -> slave)
// rd_gnt/rd_valid  : read accepted pulse, read data valid pulse (slave -> master)
// rd_data          : read pixel, held between reads (slave -> master)
// wr_req/wr_addr/wr_data : camera write request, address, pixel (master -> slave)
// wr_gnt/wr_ack    : write accepted pulse, write complete pulse (slave -> master)
interface sram_arbiter_module_if;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_gnt;
    logic        wr_ack;
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_valid, rd_data, wr_gnt, wr_ack
    );
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_valid, rd_data, wr_gnt, wr_ack
    );
endinterface

// File: rtl/sram_arbiter_module.sv
// sram_arbiter_module: two-port (VGA read / camera write) arbiter for an async 8-bit SRAM
// CLK, RST      : clock, synchronous active-high reset
// bus           : requester handshakes (sram_arbiter_module_if.slave)
// SRAM_WE/CE/OE/LB/UB : active-low SRAM strobes, all registered
// ADDR          : SRAM address, holds its last value while idle
// DATA          : SRAM low-byte data bus, driven only during write states
module sram_arbiter_module #(
    parameter int STARVE_MAX = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    sram_arbiter_module_if.slave        bus,
    output logic                        SRAM_WE,
    output logic                        SRAM_CE,
    output logic                        SRAM_OE,
    output logic                        SRAM_LB,
    output logic                        SRAM_UB,
    output logic [17:0]                 ADDR,
    inout  wire  [7:0]                  DATA
);
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3} state_t;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
    state_t state, next;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic [7:0] wdat;
    logic drive;
    assign DATA = drive ? wdat : 8'hzz;
    assign SRAM_UB = 1'b1;
    // Reads win ties until STARVE_MAX consecutive reads have been granted over a waiting write.
    always_comb begin
        next = state;
        starve_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (bus.wr_req && (!bus.rd_req || starve_cnt == SMAX)) begin
                    next = WR1;
                    starve_nxt = '0;
                end else if (bus.rd_req) begin
                    next = RD1;
                    starve_nxt = bus.wr_req ? starve_cnt + 1'b1 : '0;
                end else begin
                    starve_nxt = '0;
                end
            end
            RD1:     next = RD2;
            RD2:     next = IDLE;
            WR1:     next = WR2;
            WR2:     next = WR3;
            default: next = IDLE;
        endcase
    end
    // Strobes are registered from the next state so they change cleanly with the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            ADDR         <= '0;
            bus.rd_data  <= '0;
            bus.rd_gnt   <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.wr_gnt   <= 1'b0;
            bus.wr_ack   <= 1'b0;
            SRAM_WE      <= 1'b1;
            SRAM_CE      <= 1'b1;
            SRAM_OE      <= 1'b1;
            SRAM_LB      <= 1'b1;
            drive        <= 1'b0;
        end else begin
            state        <= next;
            starve_cnt   <= starve_nxt;
            if (next == RD1) ADDR <= bus.rd_addr;
            if (next == WR1) begin
                ADDR <= bus.wr_addr;
                wdat <= bus.wr_data;
            end
            if (state == RD2) bus.rd_data <= DATA;
            bus.rd_gnt   <= next == RD1;
            bus.wr_gnt   <= next == WR1;
            bus.rd_valid <= state == RD2;
            bus.wr_ack   <= state == WR3;
            SRAM_CE      <= next == IDLE;
            SRAM_LB      <= next == IDLE;
            SRAM_OE      <= !(next == RD1 || next == RD2);
            SRAM_WE      <= next != WR2;
            drive        <= next == WR1 || next == WR2 || next == WR3;
        end
    end
endmodule

// File: tb/tb_sram_arbiter_module.sv
// tb_sram_arbiter_module: scoreboard bench for sram_arbiter_module with an SRAM model and bus monitor
module tb_sram_arbiter_module;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB;
    logic [17:0] ADDR;
    wire  [7:0] DATA;
    logic [7:0] mem [0:262143];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit gq[$];
    logic [25:0] rq[$];
    logic [25:0] wq[$];
    logic [25:0] r_cur = '0, w_cur = '0;
    bit r_pend = 0, w_pend = 0;
    int r_gcyc = 0, w_gcyc = 0;
    sram_arbiter_module_if bus();
    sram_arbiter_module #(.STARVE_MAX(4)) dut (
        .CLK(CLK), .RST(RST), .bus(bus),
        .SRAM_WE(SRAM_WE), .SRAM_CE(SRAM_CE), .SRAM_OE(SRAM_OE),
        .SRAM_LB(SRAM_LB), .SRAM_UB(SRAM_UB), .ADDR(ADDR), .DATA(DATA)
    );
    // SRAM model drives reads; while deselected the bench holds the bus at 0 so any DUT drive shows up.
    assign DATA = (!SRAM_CE && !SRAM_OE) ? mem[ADDR] : (SRAM_CE ? 8'h00 : 8'hzz);
    always @(posedge CLK) if (!SRAM_CE && !SRAM_WE) mem[ADDR] <= DATA;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    always @(negedge CLK) begin
        if (RST) begin
            r_pend = 0;
            w_pend = 0;
        end else begin
            if (bus.rd_gnt || bus.wr_gnt) begin
                if (gq.size() == 0) chk("unexpected_gnt", 0, 1);
                else chk("gnt_order", bus.wr_gnt, gq.pop_front());
                chk("gnt_onehot", bus.rd_gnt ^ bus.wr_gnt, 1);
                if (bus.rd_gnt) begin
                    if (rq.size() == 0) chk("rd_exp_missing", 0, 1);
                    else r_cur = rq.pop_front();
                    r_pend = 1;
                    r_gcyc = cyc;
                end
                if (bus.wr_gnt) begin
                    if (wq.size() == 0) chk("wr_exp_missing", 0, 1);
                    else w_cur = wq.pop_front();
                    w_pend = 1;
                    w_gcyc = cyc;
                end
            end
            if (SRAM_CE) begin
                chk("idle_strobes", {SRAM_WE, SRAM_OE, SRAM_LB, SRAM_UB}, 4'hf);
                chk("idle_bus", DATA, 8'h00);
            end else begin
                chk("acc_lb_ub", {SRAM_LB, SRAM_UB}, 2'b01);
                if (!SRAM_OE) begin
                    chk("rd_window", r_pend && (cyc - r_gcyc) < 2, 1);
                    chk("rd_we", SRAM_WE, 1);
                    chk("rd_addr", ADDR, r_cur[25:8]);
                    chk("rd_bus", DATA, mem[ADDR]);
                end else begin
                    chk("wr_pend", w_pend && (cyc - w_gcyc) < 3, 1);
                    chk("we_window", SRAM_WE, cyc != w_gcyc + 1);
                    chk("wr_addr", ADDR, w_cur[25:8]);
                    chk("wr_data", DATA, w_cur[7:0]);
                end
            end
            if (bus.rd_valid) begin
                chk("rd_valid_lat", r_pend && cyc == r_gcyc + 2, 1);
                chk("rd_data", bus.rd_data, r_cur[7:0]);
                r_pend = 0;
            end
            if (bus.wr_ack) begin
                chk("wr_ack_lat", w_pend && cyc == w_gcyc + 3, 1);
                w_pend = 0;
            end
        end
    end
    task automatic do_wr(input logic [17:0] a, input logic [7:0] d, output int lat);
        gq.push_back(1'b1);
        wq.push_back({a, d});
        bus.wr_req = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (!bus.wr_gnt && lat < 50);
        if (!bus.wr_gnt) chk("wr_gnt_timeout", 0, 1);
        bus.wr_req = 1'b0;
    endtask
    task automatic do_rd(input logic [17:0] a, input logic [7:0] d, output int lat);
        gq.push_back(1'b0);
        rq.push_back({a, d});
        bus.rd_req = 1'b1;
        bus.rd_addr = a;
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (!bus.rd_gnt && lat < 50);
        if (!bus.rd_gnt) chk("rd_gnt_timeout", 0, 1);
        bus.rd_req = 1'b0;
    endtask
    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask
    initial begin
        int lat, c0, g, t;
        bus.rd_req = 0; bus.rd_addr = 0; bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0;
        tick(3);
        chk("rst_gnts", {bus.rd_gnt, bus.rd_valid, bus.wr_gnt, bus.wr_ack}, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_strobes", {SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB}, 5'h1f);
        chk("rst_bus", DATA, 8'h00);
        RST = 0;
        tick(1);
        do_wr(18'h00100, 8'hA5, lat);
        chk("wr_first_lat", lat, 1);
        tick(4);
        do_rd(18'h00100, 8'hA5, lat);
        chk("rd_first_lat", lat, 1);
        tick(3);
        chk("rd_readback", bus.rd_data, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            do_wr(18'(i), 8'(8'h11 * i), lat);
            if (i == 0) c0 = cyc;
        end
        chk("wr_b2b_rate", cyc - c0, 36);
        tick(4);
        for (int i = 0; i < 10; i++) begin
            do_rd(18'(i), 8'(8'h11 * i), lat);
            if (i == 0) c0 = cyc;
        end
        chk("rd_b2b_rate", cyc - c0, 27);
        tick(8);
        chk("rd_data_hold", bus.rd_data, 8'h99);
        for (int i = 0; i < 10; i++) begin
            gq.push_back(i == 4 || i == 9);
            if (i == 4 || i == 9) wq.push_back({18'h00200, 8'h5A});
            else rq.push_back({18'h00003, 8'h33});
        end
        bus.rd_addr = 18'h00003;
        bus.wr_addr = 18'h00200;
        bus.wr_data = 8'h5A;
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b1;
        g = 0;
        t = 0;
        while (g < 10 && t < 200) begin
            @(posedge CLK); #1;
            t++;
            if (bus.rd_gnt || bus.wr_gnt) g++;
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        chk("starve_grants", g, 10);
        tick(5);
        do_wr(18'h00300, 8'h77, lat);
        tick(1);
        chk("abort_in_wr2", SRAM_WE, 0);
        RST = 1;
        tick(1);
        chk("abort_strobes", {SRAM_WE, SRAM_CE, SRAM_OE}, 3'b111);
        chk("abort_bus", DATA, 8'h00);
        chk("abort_outs", {bus.wr_ack, bus.wr_gnt, bus.rd_valid}, 0);
        chk("abort_addr", ADDR, 0);
        RST = 0;
        tick(5);
        do_wr(18'h00301, 8'h88, lat);
        chk("post_rst_wr_lat", lat, 1);
        tick(4);
        do_rd(18'h00301, 8'h88, lat);
        tick(4);
        chk("post_rst_readback", bus.rd_data, 8'h88);
        chk("queues_empty", gq.size() + rq.size() + wq.size(), 0);
        chk("nothing_pending", {r_pend, w_pend}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_arbiter_module.md
SRAM_ARBITER_MODULE -- requirements
Module: sram_arbiter_module

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive read grants while a write is pending.
REQ-002 SHALL have port CLK  in  1: single clock; all logic on its rising edge.
REQ-003 SHALL have port RST  in  1: reset, synchronous, active-high.
REQ-004 SHALL have ports rd_req in 1, rd_addr in 18: VGA read request and pixel address.
REQ-005 SHALL have ports rd_gnt out 1, rd_valid out 1, rd_data out 8: read accepted pulse, data-valid pulse, read pixel.
REQ-006 SHALL have ports wr_req in 1, wr_addr in 18, wr_data in 8: camera write request, address, pixel.
REQ-007 SHALL have ports wr_gnt out 1, wr_ack out 1: write accepted pulse, write-complete pulse.
REQ-008 SHALL have ports SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB  out  1 each: SRAM strobes, active-low.
REQ-009 SHALL have ports ADDR out 18 (SRAM address) and DATA inout 8 (SRAM low-byte data bus).

Function
REQ-010 SHALL implement FSM states IDLE, RD1, RD2, WR1, WR2, WR3; all outputs registered.
REQ-011 In IDLE, SHALL sample rd_req/wr_req and, on grant, latch the granted address (and wr_data) into internal registers.
REQ-012 Arbitration in IDLE: only rd_req -> RD1; only wr_req -> WR1; neither -> stay IDLE.
REQ-013 Both requests with starve_cnt < STARVE_MAX -> RD1, starve_cnt incremented (saturating at STARVE_MAX).
REQ-014 Both requests with starve_cnt == STARVE_MAX -> WR1.
REQ-015 starve_cnt SHALL clear to 0 on every write grant and in any IDLE cycle with wr_req low.
REQ-016 Read sequence: RD1 -> RD2 -> IDLE; rd_gnt=1 for the single RD1 cycle.
REQ-017 RD1 and RD2: ADDR = latched address, SRAM_CE=0, SRAM_OE=0, SRAM_WE=1, SRAM_LB=0, SRAM_UB=1, DATA Hi-Z.
REQ-018 DATA SHALL be sampled at the end of RD2; rd_data updated and rd_valid=1 for exactly the following IDLE cycle.
REQ-019 Read latency: 3 cycles from the IDLE cycle sampling rd_req to rd_valid; minimum 3 cycles per read.
REQ-020 Write sequence: WR1 -> WR2 -> WR3 -> IDLE; wr_gnt=1 for the single WR1 cycle.
REQ-021 WR1..WR3: ADDR and DATA driven from latched values; SRAM_CE=0, SRAM_OE=1, SRAM_LB=0, SRAM_UB=1.
REQ-022 SRAM_WE=0 only in WR2; SRAM_WE=1 in WR1 and WR3 (address/data setup and hold).
REQ-023 wr_ack=1 for exactly the IDLE cycle following WR3; minimum 4 cycles per write.
REQ-024 DATA SHALL be driven only in WR1..WR3 and Hi-Z in all other states; SRAM_OE and DATA drive never active together.
REQ-025 In IDLE: SRAM_CE=1, SRAM_OE=1, SRAM_WE=1, SRAM_LB=1, SRAM_UB=1; ADDR holds its last value.
REQ-026 Requesters hold req/addr/data until their gnt pulse; req still high in the cycle after gnt is a new request.
REQ-027 Requests changing during RD1..WR3 SHALL be ignored until the next IDLE cycle.
REQ-028 rd_data SHALL hold its value between reads.

Reset
REQ-029 RST=1 at a clock edge SHALL force state IDLE, starve_cnt=0, ADDR=0, rd_data=0, all gnt/valid/ack outputs 0.
REQ-030 Under reset all SRAM strobes=1 and DATA=Hi-Z.
REQ-031 Reset during RD1..WR3 SHALL abort the access with no rd_valid/wr_ack; the aborted write may be incomplete.

Verification
REQ-032 Single write addr 0x00100, data 0xA5 -> wr_gnt next cycle; SRAM_WE low exactly 1 cycle with ADDR=0x00100, DATA=0xA5; wr_ack 3 cycles after wr_gnt.
REQ-033 Read back 0x00100 from SRAM model -> rd_gnt, then rd_valid with rd_data=0xA5 3 cycles after request sampled; OE low 2 cycles, DATA never driven.
REQ-034 rd_req and wr_req held continuously, STARVE_MAX=4 -> grant order R,R,R,R,W,R,R,R,R,W...; no write waits more than 4 reads.
REQ-035 Back-to-back writes 0..9 then reads 0..9 -> data matches; one write per 4 cycles, one read per 3 cycles.
REQ-036 RST pulsed in WR2 -> next cycle SRAM_WE=1, CE=1, DATA Hi-Z, state IDLE, no wr_ack; subsequent request serviced normally.
REQ-037 Bus monitor over all tests -> never SRAM_OE=0 while DATA driven by block; never SRAM_WE=0 outside WR2.
